// File: rtl/result_tx_arbiter_pkg.sv
// Shared constants, FSM states and digit-count helper for result_tx_arbiter.
// Optional message prefix is selected by RESULT_TX_ARB_PREFIX_EN.
package result_tx_arbiter_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_A     = 8'h41;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CONVERT,
    SEND,
    WAIT_LO,
    WAIT_HI,
    ACK
  } state_e;

  typedef enum logic [1:0] {
    PH_PFX_A,
    PH_PFX_COLON,
    PH_DIGIT,
    PH_LF
  } phase_e;

  // log10(2) ~= 77/256, so this bounds the decimal digit count
  function automatic int calc_digits(input int width);
    return (width * 77) / 256 + 1;
  endfunction

endpackage

// File: rtl/result_tx_arbiter_bcd.sv
// Iterative double-dabble: one shift per cycle after i_start,
// o_done pulses once the BCD result is stable on o_bcd.
module bin2bcd_serial
  import result_tx_arbiter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_bin,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    r_sh;
  logic [4*DIGITS-1:0] r_bcd;
  logic [4*DIGITS-1:0] w_adj;
  logic [CW-1:0]       r_cnt;
  logic                r_run;
  logic                r_done;

  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[d*4 +: 4] >= 4'd5)
        w_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh   <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_sh   <= i_bin;
      r_bcd  <= '0;
      r_cnt  <= CW'(WIDTH);
      r_run  <= 1'b1;
      r_done <= 1'b0;
    end else if (r_run) begin
      {r_bcd, r_sh} <= {w_adj[4*DIGITS-2:0], r_sh, 1'b0};
      r_cnt  <= r_cnt - 1'b1;
      r_run  <= (r_cnt != CW'(1));
      r_done <= (r_cnt == CW'(1));
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_done = r_done;
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/result_tx_arbiter.sv
// Round-robin result arbiter feeding ASCII decimal messages to spi_master.
// Define RESULT_TX_ARB_PREFIX_EN to prefix each message with "<A+i>:".
module result_tx_arbiter
  import result_tx_arbiter_pkg::*;
#(
  parameter int REQ_COUNT    = 3,
  parameter int RESULT_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [REQ_COUNT-1:0]              req_valid,
  input  logic [REQ_COUNT*RESULT_WIDTH-1:0] req_data,
  output logic [REQ_COUNT-1:0]              req_ack,
  input  logic                              spi_ready,
  output logic [7:0]                        tx_byte,
  output logic                              tx_byte_valid,
  output logic [REQ_COUNT-1:0]              ss_in,
  output logic                              busy
);

  localparam int DIGITS = calc_digits(RESULT_WIDTH);
  localparam int GW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
  localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

`ifdef RESULT_TX_ARB_PREFIX_EN
  localparam phase_e FIRST_PH = PH_PFX_A;
`else
  localparam phase_e FIRST_PH = PH_DIGIT;
`endif

  state_e              r_state;
  state_e              w_next;
  phase_e              r_phase;
  logic [GW-1:0]       r_grant;
  logic [GW-1:0]       r_last;
  logic [GW-1:0]       w_pick;
  logic                w_any;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       w_msd;
  logic [1:0]          r_wcnt;
  logic                r_lf_sent;
  logic [REQ_COUNT-1:0] r_ss;
  logic                r_busy;
  logic                w_start;
  logic                w_done;
  logic                w_strobe;
  logic [7:0]          w_byte;
  logic [3:0]          w_digit;
  logic [4*DIGITS-1:0] w_bcd;
  logic [RESULT_WIDTH-1:0] w_bin;

  assign w_any = |req_valid;
  assign w_bin = req_data[int'(r_grant)*RESULT_WIDTH +: RESULT_WIDTH];

  // nearest requester after the last grant wins
  always_comb begin
    w_pick = r_last;
    for (int k = REQ_COUNT; k >= 1; k--) begin
      if (req_valid[(int'(r_last) + k) % REQ_COUNT])
        w_pick = GW'((int'(r_last) + k) % REQ_COUNT);
    end
  end

  bin2bcd_serial #(
    .WIDTH  (RESULT_WIDTH),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clk     (clk),
    .rst_n   (reset),
    .i_start (w_start),
    .i_bin   (w_bin),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  always_comb begin
    w_msd = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_bcd[d*4 +: 4] != 4'd0)
        w_msd = PW'(d);
    end
  end

  assign w_digit = w_bcd[int'(r_ptr)*4 +: 4];

  always_comb begin
    w_byte = ASCII_LF;
    case (r_phase)
`ifdef RESULT_TX_ARB_PREFIX_EN
      PH_PFX_A:     w_byte = ASCII_A + 8'(r_grant);
      PH_PFX_COLON: w_byte = ASCII_COLON;
`endif
      PH_DIGIT:     w_byte = ASCII_ZERO + {4'h0, w_digit};
      default:      w_byte = ASCII_LF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_strobe = 1'b0;
    tx_byte  = 8'h00;
    req_ack  = '0;
    unique case (r_state)
      IDLE:    if (w_any) w_next = LATCH;
      LATCH: begin
        w_start = 1'b1;
        w_next  = CONVERT;
      end
      CONVERT: if (w_done) w_next = SEND;
      SEND: begin
        if (spi_ready) begin
          w_strobe = 1'b1;
          tx_byte  = w_byte;
          w_next   = WAIT_LO;
        end
      end
      // a master that never drops ready is assumed to have taken the byte
      WAIT_LO: begin
        if (!spi_ready || r_wcnt == 2'd3)
          w_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (spi_ready)
          w_next = r_lf_sent ? ACK : SEND;
      end
      ACK: begin
        req_ack = REQ_COUNT'(1) << r_grant;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign tx_byte_valid = w_strobe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant   <= '0;
      r_last    <= GW'(REQ_COUNT - 1);
      r_ss      <= '0;
      r_busy    <= 1'b0;
      r_phase   <= PH_DIGIT;
      r_ptr     <= '0;
      r_wcnt    <= '0;
      r_lf_sent <= 1'b0;
    end else begin
      if (r_state == IDLE && w_any)
        r_grant <= w_pick;
      if (r_state == LATCH) begin
        r_ss   <= REQ_COUNT'(1) << r_grant;
        r_busy <= 1'b1;
      end
      if (r_state == CONVERT && w_done) begin
        r_ptr     <= w_msd;
        r_phase   <= FIRST_PH;
        r_lf_sent <= 1'b0;
      end
      if (r_state == WAIT_LO && r_wcnt != 2'd3)
        r_wcnt <= r_wcnt + 1'b1;
      if (w_strobe) begin
        r_wcnt <= '0;
        case (r_phase)
`ifdef RESULT_TX_ARB_PREFIX_EN
          PH_PFX_A:     r_phase <= PH_PFX_COLON;
          PH_PFX_COLON: r_phase <= PH_DIGIT;
`endif
          PH_DIGIT: begin
            if (r_ptr == '0) r_phase <= PH_LF;
            else             r_ptr   <= r_ptr - 1'b1;
          end
          default: r_lf_sent <= 1'b1;
        endcase
      end
      if (r_state == ACK) begin
        r_ss   <= '0;
        r_busy <= 1'b0;
        r_last <= r_grant;
      end
    end
  end

  assign ss_in = r_ss;
  assign busy  = r_busy;

endmodule

// File: tb/tb_result_tx_arbiter.sv
// Scoreboard bench for result_tx_arbiter with a simple SPI ready model.
// Expected bytes/acks are queued at stimulus time and popped on output.
module tb_result_tx_arbiter;

  localparam int RC = 3;
  localparam int RW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [RC-1:0] req_valid = '0;
  logic [RC*RW-1:0] req_data = '0;
  logic [RC-1:0] req_ack;
  logic          spi_ready = 1'b1;
  logic [7:0]    tx_byte;
  logic          tx_byte_valid;
  logic [RC-1:0] ss_in;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [7:0]    exp_byte[$];
  logic [RC-1:0] exp_ss[$];
  int            exp_ack[$];
  int n_strobe = 0;
  int n_ack = 0;
  int spi_lat = 2;
  bit spi_hold = 1'b0;

  always #5 clk = ~clk;

  result_tx_arbiter #(.REQ_COUNT(RC), .RESULT_WIDTH(RW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ack       (req_ack),
    .spi_ready     (spi_ready),
    .tx_byte       (tx_byte),
    .tx_byte_valid (tx_byte_valid),
    .ss_in         (ss_in),
    .busy          (busy)
  );

  // scoreboard monitor
  initial begin
    logic [7:0]    eb;
    logic [RC-1:0] es;
    int            ea;
    forever begin
      @(negedge clk);
      if (tx_byte_valid === 1'b1) begin
        n_strobe++;
        checks++;
        if (exp_byte.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte got %h ss %b", tx_byte, ss_in);
        end else begin
          eb = exp_byte.pop_front();
          es = exp_ss.pop_front();
          if (tx_byte !== eb || ss_in !== es) begin
            errors++;
            $display("FAIL tx_byte got %h ss %b expected %h ss %b",
                     tx_byte, ss_in, eb, es);
          end
        end
      end
      if (req_ack !== '0) begin
        n_ack++;
        checks++;
        if (exp_ack.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack got %b", req_ack);
        end else begin
          ea = exp_ack.pop_front();
          if (req_ack !== (RC'(1) << ea)) begin
            errors++;
            $display("FAIL req_ack got %b expected %b", req_ack, RC'(1) << ea);
          end
        end
      end
    end
  end

  // SPI master model: ready drops for spi_lat cycles after each strobe
  initial begin
    int lo;
    bit seen;
    lo = 0;
    forever begin
      @(negedge clk);
      seen = tx_byte_valid;
      @(posedge clk);
      #1;
      if (seen) lo = spi_lat;
      else if (lo > 0) lo--;
      spi_ready = (lo == 0) && !spi_hold;
    end
  end

  task automatic push_msg(input int idx, input logic [31:0] v);
    logic [7:0]    d[$];
    logic [31:0]   t;
    logic [RC-1:0] s;
    s = RC'(1) << idx;
`ifdef RESULT_TX_ARB_PREFIX_EN
    exp_byte.push_back(8'h41 + 8'(idx)); exp_ss.push_back(s);
    exp_byte.push_back(8'h3A);           exp_ss.push_back(s);
`endif
    t = v;
    if (t == 0) d.push_front(8'h30);
    while (t != 0) begin
      d.push_front(8'h30 + 8'(t % 10));
      t = t / 10;
    end
    foreach (d[i]) begin
      exp_byte.push_back(d[i]);
      exp_ss.push_back(s);
    end
    exp_byte.push_back(8'h0A);
    exp_ss.push_back(s);
    exp_ack.push_back(idx);
  endtask

  task automatic wait_acks(input int n, input string tag);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (req_ack !== '0) begin
        req_valid = req_valid & ~req_ack;
        got++;
      end
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s ack_timeout got %0d expected %0d", tag, got, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ack, tx_byte, tx_byte_valid, ss_in, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs ack %b byte %h v %b ss %b busy %b",
               req_ack, tx_byte, tx_byte_valid, ss_in, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ss_in !== '0) begin
      errors++;
      $display("FAIL idle_after_reset busy %b ss %b", busy, ss_in);
    end
  endtask

  task automatic test_single();
    int s0;
    int cyc;
    spi_lat = 2;
    push_msg(0, 1234);
    req_data[0 +: RW] = 32'd1234;
    @(negedge clk);
    req_valid = 3'b001;
    s0 = n_strobe;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ss_in !== 3'b000) begin
      errors++;
      $display("FAIL grant_n1 busy %b ss %b expected 0 000", busy, ss_in);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ss_in !== 3'b001) begin
      errors++;
      $display("FAIL grant_n2 busy %b ss %b expected 1 001", busy, ss_in);
    end
    cyc = 2;
    while (n_strobe == s0 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc < 2 + RW || cyc >= 200) begin
      errors++;
      $display("FAIL first_byte_latency got %0d required >= %0d", cyc, 2 + RW);
    end
    wait_acks(1, "single");
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ss_in !== '0 || exp_byte.size() != 0) begin
      errors++;
      $display("FAIL single_done busy %b ss %b left %0d expected 0 000 0",
               busy, ss_in, exp_byte.size());
    end
  endtask

  task automatic test_max();
    push_msg(1, 32'hFFFF_FFFF);
    req_data[RW +: RW] = 32'hFFFF_FFFF;
    @(negedge clk);
    req_valid = 3'b010;
    wait_acks(1, "max");
    checks++;
    if (exp_byte.size() != 0) begin
      errors++;
      $display("FAIL max_drain left %0d expected 0", exp_byte.size());
    end
  endtask

  task automatic test_zero();
    push_msg(2, 0);
    req_data[2*RW +: RW] = 32'd0;
    @(negedge clk);
    req_valid = 3'b100;
    wait_acks(1, "zero");
    checks++;
    if (exp_byte.size() != 0) begin
      errors++;
      $display("FAIL zero_drain left %0d expected 0", exp_byte.size());
    end
  endtask

  task automatic test_simultaneous();
    push_msg(0, 7);
    push_msg(1, 8);
    push_msg(2, 9);
    req_data = {32'd9, 32'd8, 32'd7};
    @(negedge clk);
    req_valid = 3'b111;
    wait_acks(3, "simul");
    checks++;
    if (exp_byte.size() != 0 || exp_ack.size() != 0) begin
      errors++;
      $display("FAIL simul_drain bytes %0d acks %0d expected 0 0",
               exp_byte.size(), exp_ack.size());
    end
  endtask

  task automatic test_ready_hold();
    int s0;
    int s1;
    spi_hold = 1'b1;
    push_msg(0, 5);
    req_data[0 +: RW] = 32'd5;
    @(negedge clk);
    req_valid = 3'b001;
    s0 = n_strobe;
    repeat (RW + 4 + 50) @(negedge clk);
    checks++;
    if (n_strobe != s0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_no_strobe strobes %0d busy %b expected 0 1",
               n_strobe - s0, busy);
    end
    spi_hold = 1'b0;
    s1 = n_strobe;
    repeat (3) @(posedge clk);
    checks++;
    if (n_strobe - s1 != 1) begin
      errors++;
      $display("FAIL hold_release strobes %0d expected 1", n_strobe - s1);
    end
    wait_acks(1, "hold");
  endtask

  task automatic test_no_drop();
    spi_lat = 0;
    push_msg(1, 5);
    req_data[RW +: RW] = 32'd5;
    @(negedge clk);
    req_valid = 3'b010;
    wait_acks(1, "nodrop");
    spi_lat = 2;
    checks++;
    if (exp_byte.size() != 0) begin
      errors++;
      $display("FAIL nodrop_drain left %0d expected 0", exp_byte.size());
    end
  endtask

  task automatic test_reset_mid();
    int target;
    int cyc;
    int a0;
`ifdef RESULT_TX_ARB_PREFIX_EN
    target = n_strobe + 4;
`else
    target = n_strobe + 2;
`endif
    push_msg(1, 1234);
    req_data[RW +: RW] = 32'd1234;
    @(negedge clk);
    req_valid = 3'b010;
    cyc = 0;
    while (n_strobe < target && cyc < 400) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (n_strobe < target) begin
      errors++;
      $display("FAIL mid_reach strobes %0d expected %0d", n_strobe, target);
    end
    a0 = n_ack;
    reset = 1'b0;
    #1;
    checks++;
    if ({req_ack, tx_byte, tx_byte_valid, ss_in, busy} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs ack %b byte %h v %b ss %b busy %b",
               req_ack, tx_byte, tx_byte_valid, ss_in, busy);
    end
    exp_byte.delete();
    exp_ss.delete();
    exp_ack.delete();
    req_valid = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (n_ack != a0) begin
      errors++;
      $display("FAIL mid_no_ack acks %0d expected %0d", n_ack - a0, 0);
    end
    push_msg(0, 3);
    push_msg(1, 1234);
    req_data[0 +: RW] = 32'd3;
    req_valid = 3'b011;
    cyc = 0;
    while (busy !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (ss_in !== 3'b001) begin
      errors++;
      $display("FAIL regrant_first ss %b expected 001", ss_in);
    end
    wait_acks(2, "regrant");
    checks++;
    if (exp_byte.size() != 0 || exp_ack.size() != 0) begin
      errors++;
      $display("FAIL regrant_drain bytes %0d acks %0d expected 0 0",
               exp_byte.size(), exp_ack.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_max();
    test_zero();
    test_simultaneous();
    test_ready_hold();
    test_no_drop();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
